debug_slave_sysclk_queue: RTL and testbench

Parametrised system-clock-side command bridge for the CPU debug slave. It synchronises the virtual-JTAG update strobes (`vs_udr`, `vs_uir`) from the TCK domain and captures the shift register `sr` and instruction `ir_in` on each Update-DR. Captured commands are buffered in a FIFO and presented to the debug core through a valid/ready handshake. When a command is consumed, one-cycle take-action or take-no-action strobes are decoded per instruction code. Unlike the single-shot predecessor, it queues back-to-back JTAG commands, generalises widths and instruction count, and reports overflow.

---
 rtl/debug_slave_sysclk_queue.sv | 89 ++++++++
 tb/tb_debug_slave_sysclk_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/debug_slave_sysclk_queue.sv
// debug_slave_sysclk_queue: synchronises JTAG update strobes and queues captured debug commands for the system-clock debug core
module debug_slave_sysclk_queue #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACT_BIT     = 34
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                vs_udr,
  input  logic                                vs_uir,
  input  logic [IR_WIDTH-1:0]                 ir_in,
  input  logic [SR_WIDTH-1:0]                 sr,
  input  logic                                cmd_ready,
  input  logic                                clr_overflow,
  output logic [SR_WIDTH-1:0]                 jdo,
  output logic [IR_WIDTH-1:0]                 cmd_ir,
  output logic                                cmd_valid,
  output logic [2**IR_WIDTH-1:0]              take_action,
  output logic [2**IR_WIDTH-1:0]              take_no_action,
  output logic                                ir_update,
  output logic                                overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);
  localparam int NL = 2**IR_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int EW = IR_WIDTH + SR_WIDTH;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_prev, uir_prev;
  logic                   udr_pulse, full, pop, push, drop;
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic [NL-1:0]          lane;

  // Strobe synchronisers; preset to 1 so a level already high at reset release never looks like an edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      udr_sync <= '1;
      uir_sync <= '1;
      udr_prev <= 1'b1;
      uir_prev <= 1'b1;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];
    end

  assign udr_pulse = udr_sync[SYNC_STAGES-1] & ~udr_prev;
  assign ir_update = uir_sync[SYNC_STAGES-1] & ~uir_prev;

  assign cmd_valid = fifo_level != '0;
  assign full      = fifo_level == LW'(FIFO_DEPTH);
  assign pop       = cmd_valid & cmd_ready;
  assign push      = udr_pulse & (~full | pop);
  assign drop      = udr_pulse & full & ~pop;
  assign head      = mem[rd_ptr];

  // Command storage; ir_in/sr are quasi-static by the time the synchronised pulse arrives
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {ir_in, sr};

  // Pointers, occupancy and sticky overflow; a drop outranks a simultaneous clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      overflow   <= drop | (overflow & ~clr_overflow);
    end

  // Head presentation and one-hot pop strobes split by the action bit
  always_comb begin
    jdo            = cmd_valid ? head[SR_WIDTH-1:0] : '0;
    cmd_ir         = cmd_valid ? head[EW-1:SR_WIDTH] : '0;
    lane           = pop ? NL'(1) << cmd_ir : '0;
    take_action    = jdo[ACT_BIT] ? lane : '0;
    take_no_action = jdo[ACT_BIT] ? '0 : lane;
  end
endmodule

// File: tb/tb_debug_slave_sysclk_queue.sv
// tb_debug_slave_sysclk_queue: scoreboard bench for the debug command queue
module tb_debug_slave_sysclk_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vs_udr = 1'b0;
  logic        vs_uir = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        cmd_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  logic [37:0] jdo;
  logic [1:0]  cmd_ir;
  logic        cmd_valid;
  logic [3:0]  take_action, take_no_action;
  logic        ir_update;
  logic        overflow;
  logic [2:0]  fifo_level;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ir_cnt = 0;
  int          ir_base;
  logic [39:0] sb [$];
  logic [39:0] e;

  debug_slave_sysclk_queue dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .clr_overflow(clr_overflow), .jdo(jdo), .cmd_ir(cmd_ir),
    .cmd_valid(cmd_valid), .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop-side scoreboard: every handshake must match the oldest expected command
  always @(negedge clk) begin
    if (ir_update) ir_cnt++;
    if (cmd_valid && cmd_ready) begin
      if (sb.size() == 0) chk("pop_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("pop_jdo", jdo, e[37:0]);
        chk("pop_ir", cmd_ir, e[39:38]);
        chk("pop_act", take_action, e[34] ? 4'b1 << e[39:38] : 4'b0);
        chk("pop_noact", take_no_action, e[34] ? 4'b0 : 4'b1 << e[39:38]);
      end
    end else begin
      chk("idle_act", take_action, 0);
      chk("idle_noact", take_no_action, 0);
    end
  end

  task automatic udr_cmd(input logic [1:0] ir, input logic [37:0] s, input bit exp_push, input bit clr, input bit rdy);
    @(posedge clk); #1 ir_in = ir; sr = s; vs_udr = 1'b1;
    if (exp_push) sb.push_back({ir, s});
    @(posedge clk);
    @(posedge clk); #1 clr_overflow = clr; cmd_ready = rdy;
    @(posedge clk); #1 clr_overflow = 1'b0; cmd_ready = 1'b0;
    @(posedge clk); #1 vs_udr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input int n);
    @(posedge clk); #1 cmd_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 cmd_ready = 1'b0;
  endtask

  task automatic clear_ovf();
    @(posedge clk); #1 clr_overflow = 1'b1;
    @(posedge clk); #1 clr_overflow = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_jdo", jdo, 0);

    @(posedge clk); #1 ir_in = 2'd2; sr = 38'h04_0000_1234; vs_udr = 1'b1;
    sb.push_back({2'd2, 38'h04_0000_1234});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) chk("lat_early", cmd_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", cmd_valid, 1);
    chk("lat_jdo", jdo, 38'h04_0000_1234);
    chk("lat_ir", cmd_ir, 2);
    chk("lat_level", fifo_level, 1);
    @(posedge clk); #1 vs_udr = 1'b0;
    repeat (3) @(posedge clk);
    drain(1);
    @(negedge clk) chk("single_empty", cmd_valid, 0);

    udr_cmd(2'd0, 38'h00_0000_0055, 1, 0, 0);
    drain(1);
    @(negedge clk) chk("noact_empty", cmd_valid, 0);

    for (int i = 1; i <= 5; i++) udr_cmd(2'(i), 38'(i), i <= 4, 0, 0);
    @(negedge clk);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    drain(5);
    @(negedge clk);
    chk("drain_level", fifo_level, 0);
    chk("ovf_sticky", overflow, 1);
    clear_ovf();
    @(negedge clk) chk("ovf_clr", overflow, 0);

    for (int i = 6; i <= 9; i++) udr_cmd(2'(i), 38'(i), 1, 0, 0);
    udr_cmd(2'd2, 38'd10, 0, 1, 0);
    @(negedge clk);
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_level2", fifo_level, 4);
    clear_ovf();
    @(negedge clk) chk("ovf_clr2", overflow, 0);

    udr_cmd(2'd3, 38'h04_0000_000B, 1, 0, 1);
    @(negedge clk);
    chk("pp_ovf", overflow, 0);
    chk("pp_level", fifo_level, 4);
    drain(6);
    @(negedge clk) chk("pp_drained", fifo_level, 0);

    ir_base = ir_cnt;
    @(posedge clk); #1 reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_level", fifo_level, 0);
    chk("hold_valid", cmd_valid, 0);
    chk("hold_irupd", ir_cnt, ir_base);
    @(posedge clk); #1 vs_uir = 1'b0;
    repeat (3) @(posedge clk);
    #1 vs_uir = 1'b1;
    repeat (5) @(posedge clk);
    #1 vs_udr = 1'b0; vs_uir = 1'b0;
    @(negedge clk);
    chk("uir_once", ir_cnt, ir_base + 1);
    chk("uir_level", fifo_level, 0);
    repeat (3) @(posedge clk);

    for (int i = 20; i <= 22; i++) udr_cmd(2'(i), 38'(i) | 38'h04_0000_0000, 1, 0, 0);
    @(negedge clk) chk("mid_level", fifo_level, 3);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("mid_valid", cmd_valid, 0);
    chk("mid_jdo", jdo, 0);
    chk("mid_ir", cmd_ir, 0);
    chk("mid_lvl0", fifo_level, 0);
    chk("mid_ovf", overflow, 0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_post_level", fifo_level, 0);
    chk("mid_post_valid", cmd_valid, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
